fpu_issue_ctrl: RTL
===================

# fpu_issue_ctrl

Sequencing front end for the floating-point execute datapath. It accepts one FP operation at a time from the execute stage through a valid/ready handshake and registers the operands that drive the FPU's combinational and fixed-latency units. It counts the per-operation latency, captures the FPU result, and presents it to writeback through a second valid/ready handshake, back-pressuring issue until it is drained. `busy` is the core's FP stall source.

## Interface
Parameters:
- `LAT_ADD`, 2: cycles for fadd/fsub (1..15)
- `LAT_MUL`, 2: cycles for fmul (1..15)
- `LAT_DIV`, 8: cycles for fdiv (1..15)
- `LAT_SQRT`, 8: cycles for fsqrt (1..15)

Ports:
- `clk` in 1: single clock, rising edge
- `rstn` in 1: reset, asynchronous, active-low
- `issue_valid` in 1: execute stage offers an op
- `issue_ready` out 1: controller can accept
- `issue_op` in 4: 0 fadd, 1 fsub, 2 fmul, 3 fdiv, 4 fsqrt, 5 fsgnj, 6 fsgnjn, 7 fsgnjx, 8 fcvtws, 9 fmvxw, 10 feq, 11 fle, 12 fcvtsw, 13 fmvwx; 14–15 illegal
- `issue_rd` in 5: destination register index
- `issue_rs1_v`, `issue_frs1_v`, `issue_frs2_v` in 32 each: operands
- `fu_op` out 4: held op to the FPU
- `fu_rs1_v`, `fu_frs1_v`, `fu_frs2_v` out 32 each: held operands to the FPU
- `fu_result` in 32: FPU result for `fu_op`
- `wb_valid` out 1: result available
- `wb_ready` in 1: writeback accepts
- `wb_data` out 32: captured result
- `wb_rd` out 5: destination index
- `wb_to_int` out 1: destination is the integer RF (ops 8, 9, 10, 11)
- `wb_err` out 1: op was illegal (14/15)
- `busy` out 1: state ≠ IDLE

## Operation
States are IDLE, BUSY and DONE. There is a 4-bit down-counter `cnt`.
- **IDLE:** `issue_ready`=1.
  - On `issue_valid`, latch op, rd and operands into `fu_*`/`wb_rd`.
  - Set `cnt`=LAT(op)−1, where LAT is the parameter for ops 0–4 and 1 for all others.
  - Go to BUSY.
- **BUSY:** `issue_ready`=0.
  - If `cnt`≠0, decrement.
  - If `cnt`=0, capture `fu_result` into `wb_data` and go to DONE.
  - For an illegal op, capture 0 instead and set `wb_err`=1.
- **DONE:** `wb_valid`=1.
  - `wb_data`, `wb_rd`, `wb_to_int` and `wb_err` stay stable until `wb_ready`.
  - On `wb_ready`, go to IDLE.
- `fu_*` stay unchanged from accept until the next accept. `fu_*` are never changed while in BUSY.
- `issue_*` values outside an accepting handshake are ignored.
- `wb_to_int` is decoded at accept and registered.

## Timing
- Reset (`rstn`=0, asynchronous):
  - State IDLE, `cnt`=0.
  - All `fu_*` and `wb_*` outputs are 0, and `busy`=0.
  - `issue_ready`=1.
- Accept handshake in cycle 0:
  - BUSY during cycles 1..LAT.
  - `fu_result` is sampled at the end of cycle LAT.
  - `wb_valid` rises in cycle LAT+1.
  - Minimum op-to-wb latency is 2 cycles (LAT=1).
- With `wb_ready` held high, `wb_valid` is high for exactly 1 cycle.
- With `wb_ready` held low, `wb_valid` stays high indefinitely and the outputs are held.
- Without the macro, the throughput is one op per LAT+2 cycles. IDLE always lasts at least 1 cycle after the writeback handshake.
- Reset asserted mid-BUSY or mid-DONE:
  - The in-flight op is dropped and no `wb_valid` is produced.
  - After reset is released, the block is in IDLE.

## Configuration
- `FPU_ISSUE_B2B_EN` defined:
  - In DONE, `issue_ready`=`wb_ready`.
  - If the writeback handshake and `issue_valid` occur in the same cycle, the new op is latched and the state goes directly to BUSY. Throughput becomes one op per LAT+1 cycles.
  - If `issue_valid`=0 in that cycle, the state goes to IDLE.
- Undefined: `issue_ready` is high only in IDLE.

## Test plan
- Reset, then fadd (op 0) with frs1=0x3F800000, frs2=0x40000000 and the FPU model returning 0x40400000, `wb_ready`=1:
  - `wb_valid` is high only in cycle 3.
  - `wb_data`=0x40400000, `wb_to_int`=0.
- fdiv (op 3) with LAT_DIV=8:
  - `busy` is high cycles 1–9.
  - `issue_ready`=0 throughout.
  - `fu_frs1_v`/`fu_frs2_v` are unchanged while `issue_*` toggles randomly.
- feq (op 10), rd=5, with `wb_ready` low for 4 cycles after `wb_valid`:
  - `wb_valid` is held high.
  - `wb_data`, `wb_rd`=5 and `wb_to_int`=1 are stable.
  - The handshake completes in the cycle `wb_ready` rises.
- Illegal op 15:
  - `wb_valid` arrives at cycle 2.
  - `wb_data`=0, `wb_err`=1.
- `rstn` is pulsed low in cycle 4 of an fsqrt:
  - Outputs clear immediately and no `wb_valid` follows.
  - The next fmul completes normally at cycle 3.
- With `FPU_ISSUE_B2B_EN`, two fsgnj ops are offered continuously with `wb_ready`=1:
  - The second accept coincides with the first `wb_valid` cycle.
  - Without the macro, it occurs one cycle later.

Source files
------------

// File: rtl/fpu_issue_ctrl_if.sv
// Handshake and operand bundle between execute, the FPU datapath and writeback
// for fpu_issue_ctrl. The controller uses the slave modport; its environment uses master.
interface fpu_issue_ctrl_if;
   logic        issue_valid;
   logic        issue_ready;
   logic [3:0]  issue_op;
   logic [4:0]  issue_rd;
   logic [31:0] issue_rs1_v;
   logic [31:0] issue_frs1_v;
   logic [31:0] issue_frs2_v;
   logic [3:0]  fu_op;
   logic [31:0] fu_rs1_v;
   logic [31:0] fu_frs1_v;
   logic [31:0] fu_frs2_v;
   logic [31:0] fu_result;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_to_int;
   logic        wb_err;
   logic        busy;

   modport master (
      output issue_valid, issue_op, issue_rd, issue_rs1_v, issue_frs1_v, issue_frs2_v,
      output fu_result, wb_ready,
      input  issue_ready, fu_op, fu_rs1_v, fu_frs1_v, fu_frs2_v,
      input  wb_valid, wb_data, wb_rd, wb_to_int, wb_err, busy
   );

   modport slave (
      input  issue_valid, issue_op, issue_rd, issue_rs1_v, issue_frs1_v, issue_frs2_v,
      input  fu_result, wb_ready,
      output issue_ready, fu_op, fu_rs1_v, fu_frs1_v, fu_frs2_v,
      output wb_valid, wb_data, wb_rd, wb_to_int, wb_err, busy
   );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FP issue sequencer: holds operands for the FPU, times the op latency and hands the
// result to writeback. Define FPU_ISSUE_B2B_EN to accept a new op during the wb handshake.
module fpu_issue_ctrl #(
   parameter int unsigned LAT_ADD  = 2,
   parameter int unsigned LAT_MUL  = 2,
   parameter int unsigned LAT_DIV  = 8,
   parameter int unsigned LAT_SQRT = 8
) (
   input logic              clk,
   input logic              rstn,
   fpu_issue_ctrl_if.slave  io_fpu
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e      r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic [3:0]  r_op;
   logic [4:0]  r_rd;
   logic [31:0] r_rs1, r_frs1, r_frs2, r_data;
   logic        r_to_int, r_err;
   logic        w_ready, w_accept, w_capture, w_illegal;

   // Counter preload is latency minus one; non-arithmetic and illegal ops take one cycle.
   function automatic logic [3:0] lat_m1(input logic [3:0] op);
      case (op)
         4'd0, 4'd1: return 4'(LAT_ADD - 1);
         4'd2:       return 4'(LAT_MUL - 1);
         4'd3:       return 4'(LAT_DIV - 1);
         4'd4:       return 4'(LAT_SQRT - 1);
         default:    return 4'd0;
      endcase
   endfunction

   assign w_illegal = (r_op[3:1] == 3'b111);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ready     = 1'b0;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         StIdle: begin
            w_ready  = 1'b1;
            w_accept = io_fpu.issue_valid;
         end
         StBusy: begin
            if (r_cnt != 4'd0) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end else begin
               w_capture   = 1'b1;
               w_state_nxt = StDone;
            end
         end
         StDone: begin
`ifdef FPU_ISSUE_B2B_EN
            w_ready = io_fpu.wb_ready;
            if (io_fpu.wb_ready) begin
               w_state_nxt = StIdle;
               w_accept    = io_fpu.issue_valid;
            end
`else
            if (io_fpu.wb_ready) w_state_nxt = StIdle;
`endif
         end
         default: w_state_nxt = StIdle;
      endcase
      if (w_accept) begin
         w_state_nxt = StBusy;
         w_cnt_nxt   = lat_m1(io_fpu.issue_op);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= StIdle;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_op     <= 4'd0;
         r_rd     <= 5'd0;
         r_rs1    <= 32'd0;
         r_frs1   <= 32'd0;
         r_frs2   <= 32'd0;
         r_to_int <= 1'b0;
         r_data   <= 32'd0;
         r_err    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op     <= io_fpu.issue_op;
            r_rd     <= io_fpu.issue_rd;
            r_rs1    <= io_fpu.issue_rs1_v;
            r_frs1   <= io_fpu.issue_frs1_v;
            r_frs2   <= io_fpu.issue_frs2_v;
            r_to_int <= (io_fpu.issue_op[3:2] == 2'b10);
         end
         if (w_capture) begin
            r_data <= w_illegal ? 32'd0 : io_fpu.fu_result;
            r_err  <= w_illegal;
         end
      end
   end

   assign io_fpu.issue_ready = w_ready;
   assign io_fpu.fu_op       = r_op;
   assign io_fpu.fu_rs1_v    = r_rs1;
   assign io_fpu.fu_frs1_v   = r_frs1;
   assign io_fpu.fu_frs2_v   = r_frs2;
   assign io_fpu.wb_valid    = (r_state == StDone);
   assign io_fpu.wb_data     = r_data;
   assign io_fpu.wb_rd       = r_rd;
   assign io_fpu.wb_to_int   = r_to_int;
   assign io_fpu.wb_err      = r_err;
   assign io_fpu.busy        = (r_state != StIdle);

endmodule
